cuenta_unos_param: RTL and testbench

- Parametrised successor of the 3-bit ones counter.
- Loads a W-bit operand on `start` and counts its ones, or its zeros in zero mode, by shifting one bit per cycle into an accumulator.
- Built as a datapath (shift register, accumulator, iteration counter) driven by a hardwired control unit.
- Adds three things to the previous generation: a `busy`/`done` handshake, count-zeros mode, and optional early termination.

---
 rtl/cuenta_unos_param_pkg.sv | 24 ++
 rtl/cuenta_unos_param_uc.sv | 66 ++++++
 rtl/cuenta_unos_param.sv | 85 ++++++++
 tb/tb_cuenta_unos_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cuenta_unos_param_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cuenta_pkg
// Description : Shared definitions for the parametrised ones/zeros counter:
//               control-state encoding and default count-width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package cuenta_pkg;

    // Control states, two-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Width needed to hold any count from 0 up to and including w
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : cuenta_pkg
`default_nettype wire

// File: rtl/cuenta_unos_param_uc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uc_cuenta_param
// Description : Hardwired control unit of the ones/zeros counter. Sequences
//               load -> shift -> done and produces the busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_cuenta_param
    import cuenta_pkg::*;
(
    input  logic clk,
    input  logic rst_i,
    input  logic start_i,
    input  logic last_i,
    input  logic empty_i,
    input  logic zero_load_i,
    output logic load_o,
    output logic shift_o,
    output logic ocupado_o,
    output logic fin_o
);

    state_t state_q;
    state_t state_d;

    // State register, asynchronous active-high reset
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; start is only honoured outside SHIFT
    always_comb begin
        state_d   = state_q;
        load_o    = 1'b0;
        shift_o   = 1'b0;
        ocupado_o = 1'b0;
        fin_o     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                fin_o = (state_q == DONE);
                if (start_i) begin
                    load_o  = 1'b1;
                    // An all-zero operand in early mode has nothing to count
                    state_d = zero_load_i ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift_o   = 1'b1;
                ocupado_o = 1'b1;
                if (last_i || empty_i) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : uc_cuenta_param
`default_nettype wire

// File: rtl/cuenta_unos_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cuenta_unos_param
// Description : Counts the ones (modo=0) or zeros (modo=1) of a W-bit operand,
//               one bit per cycle, with busy/done handshake and optional
//               early termination once no counted bits remain.
// Revision    : 1.0 - initial release
// ============================================================================
module cuenta_unos_param
    import cuenta_pkg::*;
#(
    parameter int W     = 8,
    parameter int CW    = cw_of(W),
    parameter bit EARLY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          modo,
    input  logic [W-1:0]  valor,
    output logic [CW-1:0] cuenta,
    output logic          ocupado,
    output logic          fin
);

    logic [W-1:0]  q_q,   q_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] it_q,  it_d;

    logic [W-1:0]  eff;
    logic          load, shift, last, empty, zero_load;

    // Zero mode counts the ones of the inverted operand
    assign eff       = modo ? ~valor : valor;
    assign zero_load = EARLY && (eff == '0);
    assign last      = (it_q == CW'(W - 1));
    assign empty     = EARLY && ((q_q >> 1) == '0);

    uc_cuenta_param u_uc (
        .clk         (clk),
        .rst_i       (reset),
        .start_i     (start),
        .last_i      (last),
        .empty_i     (empty),
        .zero_load_i (zero_load),
        .load_o      (load),
        .shift_o     (shift),
        .ocupado_o   (ocupado),
        .fin_o       (fin)
    );

    // Datapath next state: load operand or consume its LSB
    always_comb begin
        q_d   = q_q;
        acc_d = acc_q;
        it_d  = it_q;
        if (load) begin
            q_d   = eff;
            acc_d = '0;
            it_d  = '0;
        end else if (shift) begin
            acc_d = acc_q + CW'(q_q[0]);
            q_d   = q_q >> 1;
            it_d  = it_q + CW'(1);
        end
    end

    // Datapath registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            acc_q <= '0;
            it_q  <= '0;
        end else begin
            q_q   <= q_d;
            acc_q <= acc_d;
            it_q  <= it_d;
        end
    end

    assign cuenta = acc_q;

endmodule : cuenta_unos_param
`default_nettype wire

// File: tb/tb_cuenta_unos_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cuenta_unos_param
// Description : Self-checking bench for cuenta_unos_param. Three instances
//               (W=8 EARLY=0, W=8 EARLY=1, W=3) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cuenta_unos_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       modo;
    logic [7:0] valor;

    logic [3:0] cuenta_a, cuenta_b;
    logic [1:0] cuenta_c;
    logic       ocu_a, ocu_b, ocu_c;
    logic       fin_a, fin_b, fin_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cuenta_unos_param #(.W(8), .EARLY(1'b0)) u_a (
        .clk(clk), .reset(reset), .start(start), .modo(modo), .valor(valor),
        .cuenta(cuenta_a), .ocupado(ocu_a), .fin(fin_a));

    cuenta_unos_param #(.W(8), .EARLY(1'b1)) u_b (
        .clk(clk), .reset(reset), .start(start), .modo(modo), .valor(valor),
        .cuenta(cuenta_b), .ocupado(ocu_b), .fin(fin_b));

    cuenta_unos_param #(.W(3), .EARLY(1'b0)) u_c (
        .clk(clk), .reset(reset), .start(start), .modo(modo), .valor(valor[2:0]),
        .cuenta(cuenta_c), .ocupado(ocu_c), .fin(fin_c));

    function automatic logic [31:0] fin_of(input int d);
        case (d)
            0:       return {31'd0, fin_a};
            1:       return {31'd0, fin_b};
            default: return {31'd0, fin_c};
        endcase
    endfunction

    function automatic logic [31:0] ocu_of(input int d);
        case (d)
            0:       return {31'd0, ocu_a};
            1:       return {31'd0, ocu_b};
            default: return {31'd0, ocu_c};
        endcase
    endfunction

    function automatic logic [31:0] cnt_of(input int d);
        case (d)
            0:       return {28'd0, cuenta_a};
            1:       return {28'd0, cuenta_b};
            default: return {30'd0, cuenta_c};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: count the selected bit value among the low w bits; latency is
    // the number of edges after the start edge until fin rises.
    function automatic void model(input int w, input bit early, input bit m,
                                  input logic [7:0] v, output int cnt, output int lat);
        int msb;
        cnt = 0;
        msb = -1;
        for (int i = 0; i < w; i++) begin
            if ((v[i] ^ m) == 1'b1) begin
                cnt++;
                msb = i;
            end
        end
        lat = early ? msb + 1 : w;
    endfunction

    // One full transaction on all three instances, checked every cycle
    task automatic run_txn(input bit m, input logic [7:0] v,
                           input int c8, input int le, input int c3);
        int lat [3];
        int cnt [3];
        lat = '{8, le, 3};
        cnt = '{c8, c8, c3};
        @(negedge clk);
        start = 1'b1;
        modo  = m;
        valor = v;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b0;
                modo  = 1'($urandom);
                valor = 8'($urandom);
            end
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("fin dut%0d v=%h m=%0d k=%0d", d, v, m, k),
                    fin_of(d), (k >= lat[d]) ? 32'd1 : 32'd0);
                chk($sformatf("ocupado dut%0d v=%h m=%0d k=%0d", d, v, m, k),
                    ocu_of(d), (k < lat[d]) ? 32'd1 : 32'd0);
                if (k >= lat[d])
                    chk($sformatf("cuenta dut%0d v=%h m=%0d k=%0d", d, v, m, k),
                        cnt_of(d), 32'(cnt[d]));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit         m;
        logic [7:0] v;
        int         c8;
        int         lat_early;
        int         c3;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int c8, le, c3, dummy;
        bit m;
        logic [7:0] v;

        vecs[0] = '{1'b0, 8'b1011_0110, 5, 8, 2};
        vecs[1] = '{1'b1, 8'b1011_0110, 3, 7, 1};
        vecs[2] = '{1'b0, 8'hFF,        8, 8, 3};
        vecs[3] = '{1'b0, 8'b0000_0101, 2, 3, 2};
        vecs[4] = '{1'b0, 8'h00,        0, 0, 0};
        vecs[5] = '{1'b1, 8'hFF,        0, 0, 0};

        reset = 1'b1;
        start = 1'b0;
        modo  = 1'b0;
        valor = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset cuenta dut%0d", d), cnt_of(d), 32'd0);
            chk($sformatf("reset ocupado dut%0d", d), ocu_of(d), 32'd0);
            chk($sformatf("reset fin dut%0d", d), fin_of(d), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed table, run back to back so most starts come from DONE
        foreach (vecs[i])
            run_txn(vecs[i].m, vecs[i].v, vecs[i].c8, vecs[i].lat_early, vecs[i].c3);

        // start re-asserted in the middle of SHIFT must be ignored
        do_reset();
        @(negedge clk);
        start = 1'b1;
        modo  = 1'b0;
        valor = 8'b1011_0110;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                start = 1'b1;
                valor = 8'hFF;
            end
            if (k == 3) start = 1'b0;
            chk($sformatf("midstart fin k=%0d", k), {31'd0, fin_a}, (k >= 8) ? 32'd1 : 32'd0);
            chk($sformatf("midstart ocupado k=%0d", k), {31'd0, ocu_a}, (k < 8) ? 32'd1 : 32'd0);
            if (k >= 8) chk($sformatf("midstart cuenta k=%0d", k), {28'd0, cuenta_a}, 32'd5);
        end

        // Asynchronous reset between edges aborts a count in progress
        do_reset();
        @(negedge clk);
        start = 1'b1;
        modo  = 1'b0;
        valor = 8'b1011_0110;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-abort cuenta", {28'd0, cuenta_a}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("abort cuenta", {28'd0, cuenta_a}, 32'd0);
        chk("abort ocupado", {31'd0, ocu_a}, 32'd0);
        chk("abort fin", {31'd0, fin_a}, 32'd0);
        chk("abort ocupado early", {31'd0, ocu_b}, 32'd0);
        reset = 1'b0;
        run_txn(1'b0, 8'b0000_0001, 1, 1, 1);

        // Randomised transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            m = 1'($urandom);
            v = 8'($urandom);
            if (n % 8 == 0) v = 8'($urandom_range(0, 3));
            model(8, 1'b0, m, v, c8, dummy);
            model(8, 1'b1, m, v, dummy, le);
            model(3, 1'b0, m, v, c3, dummy);
            run_txn(m, v, c8, le, c3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_cuenta_unos_param
`default_nettype wire
